// File: rtl/instr_issue_queue.sv
// Instruction issue queue: circular FIFO feeding one word per cycle, with NOP stalls after
// streaming opcodes. Define INSTR_ISSUE_QUEUE_BYPASS_EN for cut-through issue into an empty queue.
module instr_issue_queue #(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned STREAM_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [63:0]              host_instr,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic                     flush,
  output logic [63:0]              instruction,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     busy
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned StallW = $clog2(STREAM_CYCLES + 1);

  localparam logic [4:0]        OpMac     = 5'b00001;
  localparam logic [4:0]        OpSendW   = 5'b00010;
  localparam logic [63:0]       NopWord   = 64'h1F;
  localparam logic [StallW-1:0] StallLast = StallW'(STREAM_CYCLES - 1);

  typedef enum logic {StIssue, StStall} state_e;

  state_e              state_q, state_d;
  logic [StallW-1:0]   stall_cnt_q, stall_cnt_d;
  logic [63:0]         instr_q, instr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [63:0]         mem_q [DEPTH];

  logic push, pop, wr_en, bypass;

  // Ready depends only on the registered count, so a same-cycle pop never opens a full queue.
  assign host_ready  = (count_q != CntW'(DEPTH)) && !flush;
  assign push        = host_valid && host_ready;
  assign instruction = instr_q;
  assign q_count     = count_q;
  assign busy        = (count_q != '0) || (state_q == StStall);

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    instr_d     = instr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    pop         = 1'b0;
    bypass      = 1'b0;
    wr_en       = 1'b0;

    if (flush) begin
      state_d     = StIssue;
      stall_cnt_d = '0;
      instr_d     = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
    end else begin
      case (state_q)
        StIssue: begin
          if (count_q != '0) begin
            pop     = 1'b1;
            instr_d = mem_q[rd_ptr_q];
`ifdef INSTR_ISSUE_QUEUE_BYPASS_EN
          end else if (push) begin
            bypass  = 1'b1;
            instr_d = host_instr;
`endif
          end else begin
            instr_d = '0;
          end
          if (instr_d[4:0] == OpMac || instr_d[4:0] == OpSendW) state_d = StStall;
        end
        StStall: begin
          instr_d = NopWord;
          if (stall_cnt_q == StallLast) begin
            stall_cnt_d = '0;
            state_d     = StIssue;
          end else begin
            stall_cnt_d = stall_cnt_q + StallW'(1);
          end
        end
        default: state_d = StIssue;
      endcase

      wr_en = push && !bypass;
      if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (wr_en && !pop)      count_d = count_q + CntW'(1);
      else if (!wr_en && pop) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIssue;
      stall_cnt_q <= '0;
      instr_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      instr_q     <= instr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= host_instr;
  end

endmodule
